// File: rtl/double_mult_issue_queue_pkg.sv
// Shared types for the multiplier operand-pair issue queue.
// The tag type matches the tag the double-precision multiplier consumes.
package double_mult_issue_queue_pkg;

  localparam int DMQ_DEPTH = 8;
  localparam int TAG_W     = 8;

  typedef logic [TAG_W-1:0] TAG;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    TAG          tag;
  } dmq_entry_t;

  localparam int ENTRY_W = $bits(dmq_entry_t);

endpackage

// File: rtl/double_mult_issue_queue_circ_buf.sv
// Circular buffer for operand pairs: storage, read/write pointers and occupancy.
// The caller guarantees push only when not full and pop only when not empty.
module dmq_circ_buf
  import double_mult_issue_queue_pkg::*;
#(
  parameter int DEPTH = DMQ_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] wr_entry,
  output logic [ENTRY_W-1:0] head,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [CNT_W-1:0] count_q, count_d;
  dmq_entry_t       mem_q [DEPTH];

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push) wp_d = wp_q + PTR_W'(1);
      if (pop)  rp_d = rp_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Payload storage is not reset; the head is only meaningful when not empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= dmq_entry_t'(wr_entry);
  end

  assign head  = mem_q[rp_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/double_mult_issue_queue.sv
// Issue queue feeding the pipelined double multiplier: in-order, first-word
// fall-through, released only when neither the multiplier nor the system stalls.
module double_mult_issue_queue
  import double_mult_issue_queue_pkg::*;
#(
  parameter int DEPTH = DMQ_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             mult_stall,
  input  logic             global_stall,
  output logic [63:0]      out_a,
  output logic [63:0]      out_b,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_valid,
  output logic [CNT_W-1:0] count,
  output logic [31:0]      num_blocked
);

  // Handshake: a pair moves in on any edge where in_valid && in_ready, and out
  // on any edge where out_valid is high (the multiplier always takes it then).
  // in_ready ignores same-cycle pops so no stall path reaches the producer.

  logic             full, empty, push, pop;
  logic [CNT_W-1:0] count_w;
  dmq_entry_t       head, wr_entry;
  logic [31:0]      blocked_q, blocked_d;

  assign in_ready  = reset_n && !full && !flush;
  assign out_valid = !empty && !mult_stall && !global_stall && !flush;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid;

  assign wr_entry = '{a: in_a, b: in_b, tag: in_tag};

  dmq_circ_buf #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .wr_entry (wr_entry),
    .head     (head),
    .count    (count_w),
    .full     (full),
    .empty    (empty)
  );

  assign out_a   = head.a;
  assign out_b   = head.b;
  assign out_tag = head.tag;
  assign count   = count_w;

  // Held-back cycles; flush cycles are excluded and flush does not clear it.
  always_comb begin
    blocked_d = blocked_q;
    if (!empty && !out_valid && !flush && (blocked_q != '1)) begin
      blocked_d = blocked_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) blocked_q <= '0;
    else          blocked_q <= blocked_d;
  end

  assign num_blocked = blocked_q;

endmodule
